// File: rtl/band_playback_ctrl.sv
// band_playback_ctrl: streams signed samples for one mixer band from an
// external synchronous-read sample memory at the audio enable rate.
// Supports a programmable start/end region, loop or one-shot playback,
// pause/stop/retrigger and a per-band arithmetic attenuation shift.
//
// state  | meaning
// IDLE   | no playback, outputs muted on enable
// PLAY   | stepping through the region on each enable
// PAUSE  | position held, outputs muted on enable
// DONE   | one-shot region finished, waits for start or stop
module band_playback_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_DEPTH   = 4096,
    parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   pause_i,
    input  logic                   loop_en_i,
    input  logic [ADDR_WIDTH-1:0]  start_addr_i,
    input  logic [ADDR_WIDTH-1:0]  end_addr_i,
    input  logic [SHIFT_WIDTH-1:0] gain_shift_i,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic [DATA_WIDTH-1:0]  mem_dout_i,
    output logic [DATA_WIDTH-1:0]  data_out_o,
    output logic                   valid_out_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   cfg_err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned LAST_ADDR = MEM_DEPTH - 1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0]   start_q, start_d;
    logic [ADDR_WIDTH-1:0]   end_q, end_d;
    logic                    loop_q, loop_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cfg_err_q, cfg_err_d;

    logic                    cfg_ok;
    logic                    start_ok;
    logic                    at_end;
    logic                    advance;
    logic signed [DATA_WIDTH-1:0] shifted;

    // A start is ignored entirely when stop is asserted in the same cycle.
    assign cfg_ok   = (start_addr_i <= end_addr_i) && (32'(end_addr_i) <= LAST_ADDR);
    assign start_ok = start_i && !stop_i && cfg_ok;
    assign at_end   = (mem_addr_q == end_q);
    // Any higher-priority control in the same cycle mutes the enable.
    assign advance  = (state_q == S_PLAY) && enable_i && ready_q
                      && !stop_i && !start_i && !pause_i;
    assign shifted  = $signed(mem_dout_i) >>> gain_shift_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode in priority order: stop, start, pause, enable.
    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = S_IDLE;
        end else if (start_i) begin
            if (cfg_ok) state_d = S_PLAY;
        end else if (state_q == S_PLAY && pause_i) begin
            state_d = S_PAUSE;
        end else if (state_q == S_PAUSE && !pause_i) begin
            state_d = S_PLAY;
        end else if (advance && at_end && !loop_q) begin
            state_d = S_DONE;
        end
    end

    // Datapath and output decode for the next cycle.
    always_comb begin
        mem_addr_d = mem_addr_q;
        start_d    = start_q;
        end_d      = end_q;
        loop_d     = loop_q;
        ready_d    = 1'b1;
        data_d     = data_q;
        valid_d    = enable_i;
        done_d     = 1'b0;
        cfg_err_d  = start_i && !stop_i && !cfg_ok;
        busy_d     = (state_d == S_PLAY) || (state_d == S_PAUSE);
        if (enable_i) data_d = '0;
        if (start_ok) begin
            start_d    = start_addr_i;
            end_d      = end_addr_i;
            loop_d     = loop_en_i;
            mem_addr_d = start_addr_i;
            ready_d    = 1'b0;
        end else if (advance) begin
            data_d  = shifted;
            ready_d = 1'b0;
            if (!at_end)     mem_addr_d = mem_addr_q + 1'b1;
            else if (loop_q) mem_addr_d = start_q;
            else             done_d     = 1'b1;
        end
    end

    // Datapath registers, cleared by reset with no drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_q <= '0;
            start_q    <= '0;
            end_q      <= '0;
            loop_q     <= 1'b0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            start_q    <= start_d;
            end_q      <= end_d;
            loop_q     <= loop_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign data_out_o  = data_q;
    assign valid_out_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: doc/band_playback_ctrl.md
Name: band_playback_ctrl

Overview:
- Parametrised, generic successor to the per-band playback modules. Streams signed samples from a synchronous-read sample memory at the audio enable rate.
- Adds programmable start/end points, loop or one-shot mode, pause/stop/retrigger control and a per-band attenuation shift.
- One instance per band feeds the band mixer. The sample memory (BRAM/COE ROM) sits outside the block and attaches through a simple address/data port.

Parameters:
- DATA_WIDTH, 16, sample width in bits (signed two's complement)
- MEM_DEPTH, 4096, number of sample words in the attached memory
- ADDR_WIDTH, $clog2(MEM_DEPTH), memory address width
- SHIFT_WIDTH, 4, width of the attenuation shift control

Ports:
- clk  in  1  system clock (4.4 MHz); single clock domain
- rst  in  1  synchronous, active-high reset
- enable  in  1  audio-rate sample strobe (44 kHz), one cycle wide
- start  in  1  pulse: latch start_addr, end_addr and loop_en, then begin playback
- stop  in  1  pulse: abort playback and return to IDLE
- pause  in  1  level: while high, PLAY holds position
- loop_en  in  1  1 = loop region, 0 = one-shot; sampled on start
- start_addr  in  ADDR_WIDTH  first sample of the region; sampled on start
- end_addr  in  ADDR_WIDTH  last sample of the region, inclusive; sampled on start
- gain_shift  in  SHIFT_WIDTH  arithmetic right-shift applied to each output sample; live input
- mem_addr  out  ADDR_WIDTH  sample memory address (registered)
- mem_dout  in  DATA_WIDTH  sample memory read data; valid 1 clk after mem_addr changes
- data_out  out  DATA_WIDTH  signed output sample
- valid_out  out  1  one-cycle pulse per enable
- busy  out  1  high in PLAY or PAUSE
- done  out  1  one-cycle pulse when a one-shot region completes
- cfg_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (synchronous, rst high at posedge): state=IDLE, mem_addr=0, data_out=0, valid_out=0, busy=0, done=0, cfg_err=0, internal region registers=0, ready flag=0. Reset takes effect mid-playback with no drain.
- States: IDLE, PLAY, PAUSE, DONE. busy is a registered decode of PLAY or PAUSE.
- Transition priority per cycle, highest first: rst, stop, start, pause, enable.
- stop, any state: next state IDLE. mem_addr holds its value. If stop and start are both high, stop wins and start is ignored.
- start, any state:
  - Validity check: start_addr <= end_addr and end_addr <= MEM_DEPTH-1.
  - If invalid: cfg_err pulses for 1 cycle and state and registers are unchanged.
  - If valid: latch the region and loop_en, set mem_addr=start_addr, next state PLAY, clear ready.
  - A valid start during PLAY or PAUSE is a retrigger. Same actions apply.
- ready flag: set the cycle after any mem_addr update. It guarantees mem_dout matches mem_addr before the block consumes it.
- valid_out pulses on every enable in every state except reset, one cycle after the enable, so the mixer cadence never breaks.
- On enable in PLAY with ready=1:
  - data_out = mem_dout >>> gain_shift (sign-preserving; shift >= DATA_WIDTH gives 0 or -1).
  - Address advance, case 1: mem_addr != end region, so mem_addr+1.
  - Case 2: mem_addr == end and loop mode, so mem_addr wraps to the latched start.
  - Case 3: mem_addr == end and one-shot, so mem_addr holds, next state DONE and done pulses in the same cycle as that valid_out.
  - Each address advance clears ready for 1 cycle.
- On enable in PLAY with ready=0 (enable within 1 cycle of an address change): data_out=0, valid_out pulses, address does not advance. A sample is never skipped.
- On enable in IDLE, DONE or PAUSE: data_out=0 (mute), valid_out pulses, address holds.
- pause high in PLAY: next state PAUSE. pause low in PAUSE: next state PLAY, resuming at the held mem_addr. In other states, pause is ignored.
- If start and enable arrive in the same cycle, start takes effect. That enable's output is data_out=0 because the state has not yet entered PLAY.
- Single-sample region (start_addr == end_addr): loop mode repeats that sample; one-shot outputs it once, then enters DONE.
- DONE persists until start or stop. done pulses once only.
- Latency: an enable in PLAY gives data_out and valid_out on the next clk edge. The first sample after a valid start is available at the first enable arriving at least 2 cycles after start.

Test Plan:
- Memory model: MEM_DEPTH=16, mem[i]=i*100, 1-clk read latency, enable every 100 clk.
- One-shot: start_addr=2, end_addr=5, loop_en=0, gain_shift=0, start -> valid_out samples 200, 300, 400, 500. done coincides with the 500 sample. Later enables give data_out=0 and busy=0.
- Loop with wrap: start_addr=14, end_addr=15, loop_en=1 -> 1400, 1500, 1400, 1500, ... with no done. Then stop -> next enable gives 0 and state is IDLE.
- Pause/resume and gain: loop 0..3. Raise pause after the sample 100 for 3 enables -> three outputs of 0. Drop pause -> resumes at 200. Set gain_shift=2 with mem[1] forced to -400 -> outputs -100.
- Config errors and priority:
  - start_addr=6, end_addr=3 -> cfg_err pulses and state is unchanged.
  - end_addr=16 at ADDR_WIDTH=5 -> cfg_err pulses.
  - start and stop in the same cycle -> IDLE.
  - start and enable in the same cycle -> that output is 0.
- Retrigger and reset mid-play:
  - Retrigger at start_addr=8 while playing at address 3 -> next valid sample is 800.
  - Assert rst mid-PLAY -> next cycle all outputs 0, mem_addr=0, state IDLE.
  - An enable 1 cycle after start -> output 0, and the next enable delivers the start sample.
